// File: rtl/axi_achan_bridge.sv
// -----------------------------------------------------------------------------
// axi_achan_bridge
//
// Registered adapter from the memory checker's combined address channel onto
// the DDR master's separate AW and AR channels. A single holding register
// carries one request at a time. It is reloaded in the same cycle it fires, so
// a stream can move at one request per clock. Per-direction credit counters
// limit the number of uncompleted bursts. The adapter watches the B and R
// channels and raises sticky error flags for:
//   - non-OKAY responses,
//   - completions that arrive when nothing is outstanding,
//   - traffic that stops making progress.
//
// Ports
//   axi_clk, rstn              memory-domain clock, async active-low reset
//   s_a*                       combined-channel request (atype 1 = write)
//   m_awvalid/m_awready        write-address handshake
//   m_arvalid/m_arready        read-address handshake
//   m_a*                       registered payload, shared by AW and AR
//   m_b*, m_r*                 B/R channel monitors (inputs only)
//   clr_err                    clears the sticky error flags
//   wr_outstanding, rd_outstanding   live credit counts
//   idle                       registered: no held request, both counts zero
//   err_resp, err_underflow, err_timeout   sticky error flags
// -----------------------------------------------------------------------------
module axi_achan_bridge #(
  parameter int ADDR_WIDTH      = 32,
  parameter int ID_WIDTH        = 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 65535
) (
  input  logic                  axi_clk,
  input  logic                  rstn,
  input  logic [ID_WIDTH-1:0]   s_aid,
  input  logic [ADDR_WIDTH-1:0] s_aaddr,
  input  logic [7:0]            s_alen,
  input  logic [2:0]            s_asize,
  input  logic [1:0]            s_aburst,
  input  logic [1:0]            s_alock,
  input  logic                  s_avalid,
  input  logic                  s_atype,
  output logic                  s_aready,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  output logic [ID_WIDTH-1:0]   m_aid,
  output logic [ADDR_WIDTH-1:0] m_aaddr,
  output logic [7:0]            m_alen,
  output logic [2:0]            m_asize,
  output logic [1:0]            m_aburst,
  output logic [1:0]            m_alock,
  input  logic                  m_bvalid,
  input  logic                  m_bready,
  input  logic [1:0]            m_bresp,
  input  logic                  m_rvalid,
  input  logic                  m_rready,
  input  logic                  m_rlast,
  input  logic [1:0]            m_rresp,
  input  logic                  clr_err,
  output logic [3:0]            wr_outstanding,
  output logic [3:0]            rd_outstanding,
  output logic                  idle,
  output logic                  err_resp,
  output logic                  err_underflow,
  output logic                  err_timeout
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);
  localparam int         WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

  typedef enum logic {EMPTY = 1'b0, HELD = 1'b1} state_t;

  state_t state, state_nxt;
  logic   htype;
  logic   accept, out_fire, b_done, r_beat, r_done, credit_ok;
  logic [3:0] wr_nxt, rd_nxt;
  logic [WD_W-1:0] wd_cnt, wd_nxt;
  logic   wd_clr, wd_set;
  logic   resp_set, unf_set;

  // Credit count update. A simultaneous increment and decrement cancel out.
  // A decrement at zero holds the count at zero; the caller flags underflow.
  function automatic logic [3:0] cnt_update(input logic [3:0] cnt,
                                            input logic inc, input logic dec);
    logic [3:0] res;
    res = cnt;
    if (inc && !dec)
      res = cnt + 4'd1;
    else if (dec && !inc && (cnt != 4'd0))
      res = cnt - 4'd1;
    return res;
  endfunction

  // Watchdog increment, saturating at the timeout value.
  function automatic logic [WD_W-1:0] wd_sat_inc(input logic [WD_W-1:0] cnt);
    logic [WD_W-1:0] res;
    res = (cnt == WD_MAX) ? cnt : cnt + WD_W'(1);
    return res;
  endfunction

  assign m_awvalid = (state == HELD) &  htype;
  assign m_arvalid = (state == HELD) & ~htype;

  assign out_fire  = (m_awvalid & m_awready) | (m_arvalid & m_arready);
  assign b_done    = m_bvalid & m_bready;
  assign r_beat    = m_rvalid & m_rready;
  assign r_done    = r_beat & m_rlast;

  assign credit_ok = s_atype ? (wr_outstanding < MAX_CNT) : (rd_outstanding < MAX_CNT);
  // Gating with rstn keeps ready low throughout reset. Ready looks only at the
  // holding register and the credits, never at the B/R valids.
  assign s_aready  = rstn & ((state == EMPTY) | out_fire) & credit_ok;
  assign accept    = s_avalid & s_aready;

  always_comb begin
    state_nxt = state;
    if (accept)
      state_nxt = HELD;
    else if (out_fire)
      state_nxt = EMPTY;
  end

  always_ff @(posedge axi_clk or negedge rstn) begin
    if (!rstn)
      state <= EMPTY;
    else
      state <= state_nxt;
  end

  // Holding register: loads only on accept, so the payload stays stable until fire.
  always_ff @(posedge axi_clk or negedge rstn) begin
    if (!rstn) begin
      htype    <= 1'b0;
      m_aid    <= '0;
      m_aaddr  <= '0;
      m_alen   <= '0;
      m_asize  <= '0;
      m_aburst <= '0;
      m_alock  <= '0;
    end else if (accept) begin
      htype    <= s_atype;
      m_aid    <= s_aid;
      m_aaddr  <= s_aaddr;
      m_alen   <= s_alen;
      m_asize  <= s_asize;
      m_aburst <= s_aburst;
      m_alock  <= s_alock;
    end
  end

  assign wr_nxt = cnt_update(wr_outstanding, accept &  s_atype, b_done);
  assign rd_nxt = cnt_update(rd_outstanding, accept & ~s_atype, r_done);

  always_ff @(posedge axi_clk or negedge rstn) begin
    if (!rstn) begin
      wr_outstanding <= 4'd0;
      rd_outstanding <= 4'd0;
      idle           <= 1'b1;
    end else begin
      wr_outstanding <= wr_nxt;
      rd_outstanding <= rd_nxt;
      idle           <= (state_nxt == EMPTY) && (wr_nxt == 4'd0) && (rd_nxt == 4'd0);
    end
  end

  // The watchdog counts cycles without any handshake while work is pending.
  // err_timeout fires on the transition into the saturated value only. That
  // way clr_err can clear it while the stall persists.
  assign wd_clr = accept | out_fire | b_done | r_beat | idle;
  assign wd_nxt = wd_clr ? '0 : wd_sat_inc(wd_cnt);
  assign wd_set = ~wd_clr & (wd_cnt == WD_MAX - WD_W'(1));

  assign resp_set = (b_done & (m_bresp != 2'b00)) | (r_beat & (m_rresp != 2'b00));
  assign unf_set  = (b_done & (wr_outstanding == 4'd0)) | (r_done & (rd_outstanding == 4'd0));

  always_ff @(posedge axi_clk or negedge rstn) begin
    if (!rstn) begin
      wd_cnt        <= '0;
      err_resp      <= 1'b0;
      err_underflow <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      wd_cnt        <= wd_nxt;
      err_resp      <= resp_set | (err_resp      & ~clr_err);
      err_underflow <= unf_set  | (err_underflow & ~clr_err);
      err_timeout   <= wd_set   | (err_timeout   & ~clr_err);
    end
  end

endmodule

// File: tb/tb_axi_achan_bridge.sv
module tb_axi_achan_bridge;

  logic        axi_clk = 1'b0;
  logic        rstn;
  logic [7:0]  s_aid;
  logic [31:0] s_aaddr;
  logic [7:0]  s_alen;
  logic [2:0]  s_asize;
  logic [1:0]  s_aburst, s_alock;
  logic        s_avalid, s_atype, s_aready;
  logic        m_awvalid, m_awready, m_arvalid, m_arready;
  logic [7:0]  m_aid;
  logic [31:0] m_aaddr;
  logic [7:0]  m_alen;
  logic [2:0]  m_asize;
  logic [1:0]  m_aburst, m_alock;
  logic        m_bvalid, m_bready;
  logic [1:0]  m_bresp;
  logic        m_rvalid, m_rready, m_rlast;
  logic [1:0]  m_rresp;
  logic        clr_err;
  logic [3:0]  wr_outstanding, rd_outstanding;
  logic        idle, err_resp, err_underflow, err_timeout;

  int checks = 0;
  int errors = 0;

  axi_achan_bridge #(
    .ADDR_WIDTH(32), .ID_WIDTH(8), .MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .axi_clk(axi_clk), .rstn(rstn),
    .s_aid(s_aid), .s_aaddr(s_aaddr), .s_alen(s_alen), .s_asize(s_asize),
    .s_aburst(s_aburst), .s_alock(s_alock), .s_avalid(s_avalid),
    .s_atype(s_atype), .s_aready(s_aready),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_aid(m_aid), .m_aaddr(m_aaddr), .m_alen(m_alen), .m_asize(m_asize),
    .m_aburst(m_aburst), .m_alock(m_alock),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rlast(m_rlast), .m_rresp(m_rresp),
    .clr_err(clr_err),
    .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding),
    .idle(idle), .err_resp(err_resp), .err_underflow(err_underflow),
    .err_timeout(err_timeout)
  );

  always #5 axi_clk = ~axi_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs set before tick() take effect at that edge; outputs read after it.
  task automatic tick();
    @(posedge axi_clk);
    #1;
  endtask

  task automatic drive_req(input logic typ, input logic [7:0] id, input logic [31:0] addr,
                           input logic [7:0] len);
    s_avalid = 1'b1;
    s_atype  = typ;
    s_aid    = id;
    s_aaddr  = addr;
    s_alen   = len;
    s_asize  = 3'd3;
    s_aburst = 2'd1;
    s_alock  = 2'd0;
  endtask

  initial begin
    rstn = 1'b0;
    s_aid = '0; s_aaddr = '0; s_alen = '0; s_asize = '0; s_aburst = '0; s_alock = '0;
    s_avalid = 1'b1; s_atype = 1'b1;
    m_awready = 1'b0; m_arready = 1'b0;
    m_bvalid = 1'b0; m_bready = 1'b0; m_bresp = 2'd0;
    m_rvalid = 1'b0; m_rready = 1'b0; m_rlast = 1'b0; m_rresp = 2'd0;
    clr_err = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_aready", s_aready, 0);
    chk("rst_awvalid", m_awvalid, 0);
    chk("rst_arvalid", m_arvalid, 0);
    chk("rst_addr", m_aaddr, 0);
    chk("rst_wr", wr_outstanding, 0);
    chk("rst_rd", rd_outstanding, 0);
    chk("rst_idle", idle, 1);
    chk("rst_errs", {err_resp, err_underflow, err_timeout}, 0);
    s_avalid = 1'b0;
    rstn = 1'b1;
    tick();

    // Single write
    drive_req(1'b1, 8'h5A, 32'h1000_0040, 8'd3);
    #1 chk("wr1_aready", s_aready, 1);
    tick();
    s_avalid = 1'b0;
    chk("wr1_awvalid", m_awvalid, 1);
    chk("wr1_arvalid", m_arvalid, 0);
    chk("wr1_addr", m_aaddr, 32'h1000_0040);
    chk("wr1_id", m_aid, 8'h5A);
    chk("wr1_len", m_alen, 8'd3);
    chk("wr1_cnt", wr_outstanding, 1);
    chk("wr1_idle", idle, 0);
    tick();
    chk("wr1_hold_valid", m_awvalid, 1);
    chk("wr1_hold_addr", m_aaddr, 32'h1000_0040);
    m_awready = 1'b1;
    tick();
    m_awready = 1'b0;
    chk("wr1_fired", m_awvalid, 0);
    m_bvalid = 1'b1; m_bready = 1'b1; m_bresp = 2'd0;
    tick();
    m_bvalid = 1'b0;
    chk("wr1_bdone_cnt", wr_outstanding, 0);
    chk("wr1_idle_after", idle, 1);
    chk("wr1_no_resp_err", err_resp, 0);

    // Back-to-back alternating requests, both readies high
    m_awready = 1'b1; m_arready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_req(i[0], 8'(i + 16), 32'h100 * i + 32'h2000, 8'(i));
      #1 chk("b2b_aready", s_aready, 1);
      tick();
      chk("b2b_addr", m_aaddr, 32'h100 * i + 32'h2000);
      chk("b2b_id", m_aid, 64'(i + 16));
      chk("b2b_aw", m_awvalid, 64'(i % 2));
      chk("b2b_ar", m_arvalid, 64'(1 - (i % 2)));
    end
    s_avalid = 1'b0;
    tick();
    chk("b2b_wr4", wr_outstanding, 4);
    chk("b2b_rd4", rd_outstanding, 4);
    m_bvalid = 1'b1; m_bready = 1'b1;
    m_rvalid = 1'b1; m_rready = 1'b1; m_rlast = 1'b1;
    repeat (4) tick();
    m_bvalid = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0;
    chk("b2b_wr0", wr_outstanding, 0);
    chk("b2b_rd0", rd_outstanding, 0);
    chk("b2b_idle", idle, 1);
    chk("b2b_no_unf", err_underflow, 0);

    // Credit limit
    for (int i = 0; i < 4; i++) begin
      drive_req(1'b1, 8'(i), 32'h3000 + 32'(i), 8'd0);
      #1 chk("cred_aready", s_aready, 1);
      tick();
    end
    chk("cred_wr4", wr_outstanding, 4);
    drive_req(1'b0, 8'h77, 32'h4000, 8'd0);
    #1 chk("cred_rd_ok", s_aready, 1);
    tick();
    chk("cred_rd1", rd_outstanding, 1);
    drive_req(1'b1, 8'h55, 32'h3005, 8'd0);
    #1 chk("cred_5th_blocked", s_aready, 0);
    tick();
    chk("cred_wr_still4", wr_outstanding, 4);
    m_bvalid = 1'b1;
    tick();
    m_bvalid = 1'b0;
    chk("cred_wr3", wr_outstanding, 3);
    #1 chk("cred_5th_ready", s_aready, 1);
    tick();
    s_avalid = 1'b0;
    chk("cred_wr4_again", wr_outstanding, 4);
    chk("cred_5th_addr", m_aaddr, 32'h3005);
    chk("cred_5th_aw", m_awvalid, 1);
    tick();

    // Simultaneous accept and completion at count 3
    m_bvalid = 1'b1;
    tick();
    m_bvalid = 1'b0;
    chk("sim_wr3", wr_outstanding, 3);
    drive_req(1'b1, 8'h66, 32'h3006, 8'd0);
    m_bvalid = 1'b1;
    tick();
    s_avalid = 1'b0; m_bvalid = 1'b0;
    chk("sim_wr_same", wr_outstanding, 3);
    tick();
    m_bvalid = 1'b1;
    m_rvalid = 1'b1; m_rlast = 1'b1;
    tick();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    tick(); tick();
    m_bvalid = 1'b0;
    chk("sim_drain_wr", wr_outstanding, 0);
    chk("sim_drain_rd", rd_outstanding, 0);
    chk("sim_no_unf", err_underflow, 0);
    m_rvalid = 1'b1; m_rlast = 1'b1;
    tick();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    chk("unf_set", err_underflow, 1);
    chk("unf_rd0", rd_outstanding, 0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("unf_clr", err_underflow, 0);

    // Error responses
    drive_req(1'b0, 8'h21, 32'h5000, 8'd2);
    tick();
    s_avalid = 1'b0;
    tick();
    chk("resp_rd1", rd_outstanding, 1);
    m_rvalid = 1'b1; m_rresp = 2'd0; m_rlast = 1'b0;
    tick();
    chk("resp_beat0", err_resp, 0);
    m_rresp = 2'd2;
    tick();
    chk("resp_mid_beat", err_resp, 1);
    m_rresp = 2'd0; m_rlast = 1'b1;
    tick();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    chk("resp_rd0", rd_outstanding, 0);
    clr_err = 1'b1; m_bvalid = 1'b1; m_bresp = 2'd3;
    tick();
    m_bvalid = 1'b0; m_bresp = 2'd0;
    chk("resp_set_wins", err_resp, 1);
    tick();
    clr_err = 1'b0;
    chk("resp_clr", err_resp, 0);
    chk("resp_clr_unf", err_underflow, 0);

    // Timeout with one read outstanding
    drive_req(1'b0, 8'h31, 32'h6000, 8'd0);
    tick();
    s_avalid = 1'b0;
    tick();
    chk("to_rd1", rd_outstanding, 1);
    chk("to_start", err_timeout, 0);
    repeat (15) tick();
    chk("to_cycle15", err_timeout, 0);
    tick();
    chk("to_cycle16", err_timeout, 1);

    // Reset mid-hold
    m_awready = 1'b0; m_arready = 1'b0;
    drive_req(1'b1, 8'h41, 32'h7000, 8'd1);
    tick();
    chk("hold_aw", m_awvalid, 1);
    #2 rstn = 1'b0;
    #1;
    chk("arst_aw", m_awvalid, 0);
    chk("arst_addr", m_aaddr, 0);
    chk("arst_wr", wr_outstanding, 0);
    chk("arst_rd", rd_outstanding, 0);
    chk("arst_idle", idle, 1);
    chk("arst_timeout", err_timeout, 0);
    chk("arst_aready", s_aready, 0);
    s_avalid = 1'b0;
    tick();
    rstn = 1'b1;
    m_rvalid = 1'b1; m_rready = 1'b1; m_rlast = 1'b1;
    tick();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    chk("post_rst_unf", err_underflow, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_achan_bridge.md
# axi_achan_bridge

Registered adapter between the memory checker's combined address channel (`aid/aaddr/alen/asize/aburst/alock/avalid/aready/atype`) and the SoC DDR master port's separate AW and AR channels. It replaces the combinational split in the top level with one holding register. It limits outstanding write and read bursts with per-direction credit counters and watches B/R completions. It raises sticky error flags for non-OKAY responses, completion underflow and stalled traffic. It runs entirely in the memory clock domain.

## Interface
- `ADDR_WIDTH`, 32: address width.
- `ID_WIDTH`, 8: ID width.
- `MAX_OUTSTANDING`, 4: maximum un-completed bursts per direction; legal range 1–15.
- `TIMEOUT_CYCLES`, 65535: no-progress cycles before `err_timeout`; minimum 2.

Ports (clock and reset first):
- `axi_clk`  in  1  memory-domain clock.
- `rstn`  in  1  reset, asynchronous assert, active-low.
- `s_aid`, `s_aaddr`, `s_alen`, `s_asize`, `s_aburst`, `s_alock`  in  ID_WIDTH/ADDR_WIDTH/8/3/2/2  combined-channel payload.
- `s_avalid`  in  1  combined-channel valid.
- `s_atype`  in  1  1 = write, 0 = read.
- `s_aready`  out  1  combined-channel ready.
- `m_awvalid`  out  1  write-address valid.
- `m_awready`  in  1  write-address ready.
- `m_arvalid`  out  1  read-address valid.
- `m_arready`  in  1  read-address ready.
- `m_aid`, `m_aaddr`, `m_alen`, `m_asize`, `m_aburst`, `m_alock`  out  as inputs  registered payload, shared by AW and AR.
- `m_bvalid`, `m_bready`  in  1 each  B-channel monitor.
- `m_bresp`  in  2  B-channel response monitor.
- `m_rvalid`, `m_rready`, `m_rlast`  in  1 each  R-channel monitor.
- `m_rresp`  in  2  R-channel response monitor.
- `clr_err`  in  1  clears all sticky error flags.
- `wr_outstanding`, `rd_outstanding`  out  4 each  live credit counts.
- `idle`  out  1  no held request and both counts zero.
- `err_resp`  out  1  sticky: a non-OKAY response was seen.
- `err_underflow`  out  1  sticky: a completion arrived with count 0.
- `err_timeout`  out  1  sticky: no progress for `TIMEOUT_CYCLES`.

## Operation
Handshake events:
- `accept` = `s_avalid & s_aready`.
- `out_fire` = `(m_awvalid & m_awready) | (m_arvalid & m_arready)`.
- `b_done` = `m_bvalid & m_bready`.
- `r_beat` = `m_rvalid & m_rready`.
- `r_done` = `r_beat & m_rlast`.

Holding register:
- States: EMPTY and HELD.
- On `accept`, the register captures the payload and `atype`, and goes to (or stays) HELD.
- In HELD, `m_awvalid` = `htype` and `m_arvalid` = `~htype`. Only one of them is ever high.
- On `out_fire` with no `accept`, the register goes to EMPTY.
- On `out_fire` with `accept` in the same cycle, the new request is loaded, giving back-to-back throughput.
- Held payload and valid are stable until `out_fire`. There is no withdrawal.

Ready rule:
- `s_aready` = `rstn & (EMPTY | out_fire) & credit_ok`.
- `credit_ok` = `s_atype ? (wr_outstanding < MAX_OUTSTANDING) : (rd_outstanding < MAX_OUTSTANDING)`.
- `s_aready` may depend on `s_avalid`/`s_atype`. It must not depend on `m_bvalid` or `m_rvalid`.

Credit counters:
- `wr_outstanding` increments on a write `accept` and decrements on `b_done`.
- `rd_outstanding` increments on a read `accept` and decrements on `r_done`.
- Increment and decrement in the same cycle leave the count unchanged.
- A decrement at count 0 leaves the count at 0 and sets `err_underflow`.

Error flags:
- `err_resp` sets on `b_done` with `m_bresp != 0`, or on any `r_beat` with `m_rresp != 0`.
- `clr_err` clears all three flags. A set event in the same cycle wins.

Watchdog:
- The counter clears on any of `accept`, `out_fire`, `b_done`, `r_beat`, or when `idle` is high.
- Otherwise it increments, saturating at `TIMEOUT_CYCLES`.
- `err_timeout` sets in the cycle the counter reaches `TIMEOUT_CYCLES`.

## Timing
- Reset values:
  - All `m_*valid` = 0; payload = 0.
  - Counters = 0.
  - `idle` = 1.
  - `err_*` = 0.
  - `s_aready` = 0 while `rstn` is low.
- Latency: an `accept` at edge N gives `m_awvalid` or `m_arvalid` high from N+1.
- Sustained throughput is 1 request per cycle when the downstream ready is held high and credits are available.
- Counters update at the edge of the event, so a freed credit is usable in the following cycle.
- `idle` is registered.
- Reset asserted mid-burst:
  - The held request is dropped and the counters clear immediately.
  - Completions arriving after reset release count as underflow.
  - Correct behaviour then is for the upstream to also be in reset.

## Test plan
- Single write request: accept at N → `m_awvalid` at N+1 with the matching payload, `m_arvalid` stays 0, `wr_outstanding` = 1. A `b_done` with bresp 0 → count 0, `idle` = 1 next cycle.
- Back-to-back, both readies held high: 8 alternating read/write requests, all completed promptly → one request per cycle, ordering preserved, final counts 0.
- Credit limit, `MAX_OUTSTANDING` = 4: 5 writes with no B → 5th held off with `s_aready` = 0. One `b_done` → 5th accepted the next cycle. Reads are still accepted throughout.
- Simultaneous events: write accept and `b_done` in the same cycle at count 3 → count stays 3. `r_done` at count 0 → `err_underflow` = 1, count stays 0.
- Error responses: `rresp` = 2 on a middle beat → `err_resp` = 1. `clr_err` together with a new `bresp` = 3 → `err_resp` stays 1. `clr_err` alone → 0.
- Timeout, `TIMEOUT_CYCLES` = 16: one read outstanding, no R for 16 cycles → `err_timeout` set exactly at cycle 16. Reset mid-hold → all outputs return to their reset values asynchronously.
